// File: rtl/noc_rsp_packetizer.sv
// noc_rsp_packetizer: turns an AXI read-data burst into a NoC response packet.
// The packet is one header flit followed by cmd_len+1 data flits, and the last
// data flit is marked as the tail. The beat counter alone sets the packet
// length. R_LAST is only compared against the count, and a mismatch is
// reported on err_last.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a response command (cmd_ready=1)
//   HEADER | presenting the header flit until the NoC queue accepts it
//   DATA   | forwarding R beats as body/tail flits, counter counts down
module noc_rsp_packetizer #(
  parameter int AXIDW          = 32,
  parameter int NOC_FLIT_SIZE  = 34,
  parameter int MSG_TYPE_WIDTH = 5
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [2:0]                local_y,
  input  logic [2:0]                local_x,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_dst_y,
  input  logic [2:0]                cmd_dst_x,
  input  logic [MSG_TYPE_WIDTH-1:0] cmd_msg,
  input  logic [7:0]                cmd_len,
  input  logic                      R_VALID,
  output logic                      R_READY,
  input  logic [AXIDW-1:0]          R_DATA,
  input  logic [1:0]                R_RESP,
  input  logic                      R_LAST,
  output logic                      coherence_rsp_snd_wrreq,
  output logic [NOC_FLIT_SIZE-1:0]  coherence_rsp_snd_data_in,
  input  logic                      coherence_rsp_snd_full,
  output logic                      err_last,
  output logic                      err_resp
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HEADER = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;

  // Zero padding below the message field of the header flit.
  localparam int HDR_PAD = NOC_FLIT_SIZE - 14 - MSG_TYPE_WIDTH;

  logic [1:0]                state;
  logic [7:0]                cnt;
  logic [2:0]                dst_y_q;
  logic [2:0]                dst_x_q;
  logic [MSG_TYPE_WIDTH-1:0] msg_q;

  logic                      xfer;
  logic                      last_beat;
  logic [NOC_FLIT_SIZE-1:0]  header_flit;

  assign last_beat   = (cnt == 8'd0);
  assign xfer        = (state == DATA) && R_VALID && !coherence_rsp_snd_full;
  assign header_flit = {2'b10, local_y, local_x, dst_y_q, dst_x_q, msg_q, {HDR_PAD{1'b0}}};

  assign cmd_ready = (state == IDLE);
  assign R_READY   = (state == DATA) && !coherence_rsp_snd_full;

  // Flit mux: the header while in HEADER, and the beat with its preamble on transfer cycles.
  always_comb begin
    coherence_rsp_snd_wrreq   = 1'b0;
    coherence_rsp_snd_data_in = '0;
    if (state == HEADER) begin
      coherence_rsp_snd_wrreq   = !coherence_rsp_snd_full;
      coherence_rsp_snd_data_in = header_flit;
    end else if (xfer) begin
      coherence_rsp_snd_wrreq   = 1'b1;
      coherence_rsp_snd_data_in = {(last_beat ? 2'b01 : 2'b00), R_DATA};
    end
  end

  // FSM, command latch, beat counter and the registered error pulses.
  // The error pulses appear in the cycle after the offending beat.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      dst_y_q  <= 3'd0;
      dst_x_q  <= 3'd0;
      msg_q    <= '0;
      err_last <= 1'b0;
      err_resp <= 1'b0;
    end else begin
      err_last <= xfer && (R_LAST != last_beat);
      err_resp <= xfer && (R_RESP != 2'b00);
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dst_y_q <= cmd_dst_y;
            dst_x_q <= cmd_dst_x;
            msg_q   <= cmd_msg;
            cnt     <= cmd_len;
            state   <= HEADER;
          end
        end
        HEADER: begin
          if (!coherence_rsp_snd_full) state <= DATA;
        end
        DATA: begin
          if (xfer) begin
            if (last_beat) state <= IDLE;
            else           cnt   <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
